// File: rtl/mul_cell_share_ctrl.sv
// mul_cell_share_ctrl
//   Shares one 16x16 partial-product multiplier cell among NUM_REQ requesters.
//   A round-robin arbiter accepts one 32x32 multiply at a time. The sequencer
//   enables the cell for one cycle, folds its three partial products into the
//   low 32 bits of A*B, and returns the result with the requester index on a
//   valid/ready response port.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_valid_i/req_ready_o per-requester handshake (ready is one-hot)
//   req_a_i/req_b_i         operands, slice i = bits [32*i+31:32*i]
//   resp_valid_o/ready_i    response handshake
//   resp_id_o/resp_data_o   owning requester index, low 32 bits of A*B
//   cell_src1_o/src2_o      operands to the cell
//   cell_en_o               cell pipeline enable
//   cell_p1_i..cell_p3_i    registered a_lo*b_lo, a_lo*b_hi, a_hi*b_lo

module mul_cell_share_ctrl #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   input  logic [NUM_REQ*32-1:0]   req_a_i,
   input  logic [NUM_REQ*32-1:0]   req_b_i,
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i,
   output logic [ID_W-1:0]         resp_id_o,
   output logic [31:0]             resp_data_o,
   output logic [31:0]             cell_src1_o,
   output logic [31:0]             cell_src2_o,
   output logic                    cell_en_o,
   input  logic [31:0]             cell_p1_i,
   input  logic [31:0]             cell_p2_i,
   input  logic [31:0]             cell_p3_i
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUM, S_RESP} state_e;

   state_e            state_q;
   logic [31:0]       op_a_q, op_b_q;
   logic [ID_W-1:0]   resp_id_q, rr_ptr_q;
   logic [31:0]       resp_data_q;
   logic              resp_valid_q, cell_en_q;

   // ------------------------------------------------------------------
   // Round-robin search starting one past the last grant. Variable-index
   // selects are done as shifts so the index width never has to match.
   // ------------------------------------------------------------------
   logic              gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] rv_rot;
   int                cand;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      rv_rot    = '0;
      cand      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand   = (int'(rr_ptr_q) + k) % NUM_REQ;
         rv_rot = req_valid_i >> cand;
         if (!gnt_found && rv_rot[0]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(cand);
         end
      end
   end

   logic [NUM_REQ*32-1:0] a_sh, b_sh;
   logic                  req_hs;

   assign a_sh   = req_a_i >> (32 * int'(gnt_idx));
   assign b_sh   = req_b_i >> (32 * int'(gnt_idx));
   // Ready is held low during reset so no handshake is seen that the
   // registers would then ignore.
   assign req_hs = (state_q == S_IDLE) && gnt_found && !reset_i;
   assign req_ready_o = req_hs ? (NUM_REQ'(1) << gnt_idx) : '0;

   // Only the low halves of the cross products reach bits [31:0].
   logic [31:0] sum_d;
   logic        unused_hi;

   assign sum_d     = cell_p1_i + {cell_p2_i[15:0], 16'h0} + {cell_p3_i[15:0], 16'h0};
   assign unused_hi = ^{cell_p2_i[31:16], cell_p3_i[31:16]};

   // ------------------------------------------------------------------
   // Sequencer: IDLE -> MUL (cell enabled) -> SUM (cell holds) -> RESP
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
         rr_ptr_q     <= ID_W'(NUM_REQ - 1);
         resp_valid_q <= 1'b0;
         cell_en_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_hs) begin
                  op_a_q    <= a_sh[31:0];
                  op_b_q    <= b_sh[31:0];
                  resp_id_q <= gnt_idx;
                  rr_ptr_q  <= gnt_idx;
                  cell_en_q <= 1'b1;
                  state_q   <= S_MUL;
               end
            end
            S_MUL: begin
               cell_en_q <= 1'b0;
               state_q   <= S_SUM;
            end
            S_SUM: begin
               resp_data_q  <= sum_d;
               resp_valid_q <= 1'b1;
               state_q      <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               resp_valid_q <= 1'b0;
               cell_en_q    <= 1'b0;
            end
         endcase
      end
   end

   assign resp_valid_o = resp_valid_q;
   assign resp_id_o    = resp_id_q;
   assign resp_data_o  = resp_data_q;
   assign cell_src1_o  = op_a_q;
   assign cell_src2_o  = op_b_q;
   assign cell_en_o    = cell_en_q;

endmodule
